foo_gb_regmap: RTL and testbench



---
 rtl/foo_gb_pkg.sv | 29 ++
 rtl/foo_bar_regs.sv | 74 +++++++
 rtl/foo_gb_regmap.sv | 135 +++++++++++++
 tb/tb_foo_gb_regmap.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/foo_gb_pkg.sv
// foo_gb_pkg
// Shared bus geometry, region base addresses and in-region offsets for the
// ghostbus target of the foo hierarchy.
// Optional feature macro: GHOSTBUS_RAM_EN (RAM arrays present when defined).
package foo_gb_pkg;

    localparam int GB_AW = 12;
    localparam int GB_DW = 32;

    // Region bases; the region is selected by address bits [11:9]
    localparam logic [GB_AW-1:0] BASE_FOO       = 12'h000;
    localparam logic [GB_AW-1:0] BASE_BAR_0     = 12'h200;
    localparam logic [GB_AW-1:0] BASE_BAZ_BAR_1 = 12'h400;
    localparam logic [GB_AW-1:0] BASE_BAZ_BAR_0 = 12'h600;

    // Offsets inside a region (address bits [8:0])
    localparam logic [8:0] ADDR_HA_REG     = 9'h000;
    localparam logic [8:0] ADDR_HA_REG_TWO = 9'h001;
    localparam logic [8:0] ADDR_FOO_CNT    = 9'h001;
    localparam logic [8:0] BASE_FOO_RAM    = 9'h040;
    localparam logic [8:0] BASE_BAR_RAM    = 9'h100;
    localparam int         SIZE_BAR_RAM    = 'h040;

    function automatic logic region_hit(input logic [GB_AW-1:0] addr,
                                        input logic [GB_AW-1:0] base);
        return addr[11:9] == base[11:9];
    endfunction

endpackage

// File: rtl/foo_bar_regs.sv
// foo_bar_regs
// One bar register block: ha_reg (GW bits), ha_reg_two (DW bits) and,
// when GHOSTBUS_RAM_EN is defined, a 64-word RAM at offset 0x100.
// Read data is combinational and forced to zero when the block is not
// selected so the parent can OR all blocks together.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_sel        this block's region is addressed
//   i_addr       in-region word offset
//   i_we         write strobe
//   i_wdata      write data
//   o_rdata      read data (zero when unselected)
module foo_bar_regs
    import foo_gb_pkg::*;
#(
    parameter int GW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_sel,
    input  logic [8:0]    i_addr,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [GW-1:0] r_ha_reg;
    logic [DW-1:0] r_ha_reg_two;

    logic w_hit_ha;
    logic w_hit_two;

    assign w_hit_ha  = i_sel && (i_addr == ADDR_HA_REG);
    assign w_hit_two = i_sel && (i_addr == ADDR_HA_REG_TWO);

`ifdef GHOSTBUS_RAM_EN
    logic [DW-1:0] r_ram [SIZE_BAR_RAM] = '{default: '0};
    logic          w_hit_ram;

    assign w_hit_ram = i_sel && (i_addr[8:6] == BASE_BAR_RAM[8:6]);
`endif

    // RAM writes share the reset-qualified block so a write that coincides
    // with reset is dropped; the RAM itself is never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ha_reg     <= '0;
            r_ha_reg_two <= '0;
        end else if (i_we) begin
            if (w_hit_ha)
                r_ha_reg <= i_wdata[GW-1:0];
            if (w_hit_two)
                r_ha_reg_two <= i_wdata;
`ifdef GHOSTBUS_RAM_EN
            if (w_hit_ram)
                r_ram[i_addr[5:0]] <= i_wdata;
`endif
        end
    end

    always_comb begin
        o_rdata = '0;
        if (w_hit_ha)
            o_rdata[GW-1:0] = r_ha_reg;
        else if (w_hit_two)
            o_rdata = r_ha_reg_two;
`ifdef GHOSTBUS_RAM_EN
        else if (w_hit_ram)
            o_rdata = r_ram[i_addr[5:0]];
`endif
    end

endmodule

// File: rtl/foo_gb_regmap.sv
// foo_gb_regmap
// Ghostbus target for the foo hierarchy. Decodes a 12-bit word address into
// the foo local region (ha_reg, free-running counter, RAM) and three bar
// blocks, and returns registered read data one cycle after the address.
// Optional feature macro: GHOSTBUS_RAM_EN (foo RAM and bar RAMs present).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   gb_addr      word address
//   gb_dout      write data from host
//   gb_we        write strobe
//   gb_din       registered read data to host
module foo_gb_regmap
    import foo_gb_pkg::*;
#(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int GW = 8,
    parameter int RD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [GB_AW-1:0] gb_addr,
    input  logic [DW-1:0]    gb_dout,
    output logic [DW-1:0]    gb_din,
    input  logic             gb_we
);

    logic [8:0]    w_off;
    logic          w_sel_foo;
    logic          w_sel_bar_0;
    logic          w_sel_baz_bar_1;
    logic          w_sel_baz_bar_0;
    logic          w_hit_ha;
    logic          w_hit_cnt;

    logic [GW-1:0] r_ha_reg;
    logic [AW-1:0] r_cnt;

    logic [DW-1:0] w_foo_rdata;
    logic [DW-1:0] w_bar_0_rdata;
    logic [DW-1:0] w_baz_bar_1_rdata;
    logic [DW-1:0] w_baz_bar_0_rdata;

    assign w_off           = gb_addr[8:0];
    assign w_sel_foo       = region_hit(gb_addr, BASE_FOO);
    assign w_sel_bar_0     = region_hit(gb_addr, BASE_BAR_0);
    assign w_sel_baz_bar_1 = region_hit(gb_addr, BASE_BAZ_BAR_1);
    assign w_sel_baz_bar_0 = region_hit(gb_addr, BASE_BAZ_BAR_0);

    assign w_hit_ha  = w_sel_foo && (w_off == ADDR_HA_REG);
    assign w_hit_cnt = w_sel_foo && (w_off == ADDR_FOO_CNT);

`ifdef GHOSTBUS_RAM_EN
    localparam int RIW = (RD > 1) ? $clog2(RD) : 1;

    logic [DW-1:0]  r_ram [RD] = '{default: '0};
    logic           w_hit_ram;
    logic [RIW-1:0] w_ram_idx;

    // Offsets 0x040..0x07F belong to the RAM window; only the first RD
    // words are backed, the rest read 0 and ignore writes.
    assign w_hit_ram = w_sel_foo && (w_off[8:6] == BASE_FOO_RAM[8:6])
                       && (int'(w_off[5:0]) < RD);
    assign w_ram_idx = w_off[RIW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ha_reg <= '0;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + AW'(1);
            if (gb_we && w_hit_ha)
                r_ha_reg <= gb_dout[GW-1:0];
`ifdef GHOSTBUS_RAM_EN
            if (gb_we && w_hit_ram)
                r_ram[w_ram_idx] <= gb_dout;
`endif
        end
    end

    always_comb begin
        w_foo_rdata = '0;
        if (w_hit_ha)
            w_foo_rdata[GW-1:0] = r_ha_reg;
        else if (w_hit_cnt)
            w_foo_rdata[AW-1:0] = r_cnt;
`ifdef GHOSTBUS_RAM_EN
        else if (w_hit_ram)
            w_foo_rdata = r_ram[w_ram_idx];
`endif
    end

    foo_bar_regs #(.GW(GW), .DW(DW)) u_bar_0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sel   (w_sel_bar_0),
        .i_addr  (w_off),
        .i_we    (gb_we),
        .i_wdata (gb_dout),
        .o_rdata (w_bar_0_rdata)
    );

    foo_bar_regs #(.GW(GW), .DW(DW)) u_baz_bar_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sel   (w_sel_baz_bar_1),
        .i_addr  (w_off),
        .i_we    (gb_we),
        .i_wdata (gb_dout),
        .o_rdata (w_baz_bar_1_rdata)
    );

    foo_bar_regs #(.GW(GW), .DW(DW)) u_baz_bar_0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sel   (w_sel_baz_bar_0),
        .i_addr  (w_off),
        .i_we    (gb_we),
        .i_wdata (gb_dout),
        .o_rdata (w_baz_bar_0_rdata)
    );

    // Region selects are mutually exclusive and unselected sources drive
    // zero, so an OR is a sufficient mux. Counter reads return the pre-edge
    // value because r_cnt and gb_din update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gb_din <= '0;
        else
            gb_din <= w_foo_rdata | w_bar_0_rdata | w_baz_bar_1_rdata
                      | w_baz_bar_0_rdata;
    end

endmodule

// File: tb/tb_foo_gb_regmap.sv
module tb_foo_gb_regmap;

    logic        clk;
    logic        rst_n;
    logic [11:0] gb_addr;
    logic [31:0] gb_dout;
    logic [31:0] gb_din;
    logic        gb_we;

    int checks   = 0;
    int failures = 0;

`ifdef GHOSTBUS_RAM_EN
    localparam bit RAM_EN = 1'b1;
`else
    localparam bit RAM_EN = 1'b0;
`endif

    foo_gb_regmap #(.AW(24), .DW(32), .GW(8), .RD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gb_addr (gb_addr),
        .gb_dout (gb_dout),
        .gb_din  (gb_din),
        .gb_we   (gb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive at negedge so the following posedge commits the write.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        gb_addr = a;
        gb_dout = d;
        gb_we   = 1'b1;
        @(negedge clk);
        gb_we   = 1'b0;
    endtask

    // Address presented at negedge, registered at next posedge, sampled at
    // the negedge after that.
    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        gb_addr = a;
        gb_we   = 1'b0;
        @(negedge clk);
        d = gb_din;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        logic [31:0] c0, c1;

        rst_n   = 1'b0;
        gb_addr = 12'h000;
        gb_dout = 32'h0;
        gb_we   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_gb_din", gb_din, 32'h0);
        rst_n = 1'b1;

        // Reset values
        rd_chk("rst_foo_ha",   12'h000, 32'h0);
        rd_chk("rst_bar0_ha",  12'h200, 32'h0);
        rd_chk("rst_bar0_two", 12'h201, 32'h0);
        rd_chk("rst_bar1_ha",  12'h400, 32'h0);
        rd_chk("rst_bar1_two", 12'h401, 32'h0);
        rd_chk("rst_baz0_ha",  12'h600, 32'h0);
        rd_chk("rst_baz0_two", 12'h601, 32'h0);

        // Instance isolation
        wr(12'h000, 32'h25);
        wr(12'h200, 32'hBB);
        wr(12'h201, 32'hDADB00B5);
        wr(12'h400, 32'hDD);
        wr(12'h401, 32'h12345678);
        wr(12'h600, 32'hEE);
        wr(12'h601, 32'hFEDCBA98);
        rd_chk("foo_ha",   12'h000, 32'h25);
        rd_chk("bar0_ha",  12'h200, 32'hBB);
        rd_chk("bar0_two", 12'h201, 32'hDADB00B5);
        rd_chk("bar1_ha",  12'h400, 32'hDD);
        rd_chk("bar1_two", 12'h401, 32'h12345678);
        rd_chk("baz0_ha",  12'h600, 32'hEE);
        rd_chk("baz0_two", 12'h601, 32'hFEDCBA98);

        // GW truncation and unmapped region
        wr(12'h000, 32'hFFFFFF25);
        rd_chk("foo_ha_trunc", 12'h000, 32'h25);
        wr(12'h200, 32'h1234_56C3);
        rd_chk("bar0_ha_trunc", 12'h200, 32'hC3);
        wr(12'h800, 32'hCAFEF00D);
        rd_chk("unmapped_800", 12'h800, 32'h0);
        rd_chk("unmapped_e01", 12'hE01, 32'h0);
        rd_chk("after_800_foo_ha",   12'h000, 32'h25);
        rd_chk("after_800_bar0_two", 12'h201, 32'hDADB00B5);
        rd_chk("after_800_baz0_two", 12'h601, 32'hFEDCBA98);
        rd_chk("hole_foo_002", 12'h002, 32'h0);
        rd_chk("hole_bar1_002", 12'h402, 32'h0);

        // RAMs (expect 0 when compiled out)
        for (int n = 0; n < 8; n++) begin
            wr(12'h040 + 12'(n), 32'hA0 + 32'(n));
            wr(12'h300 + 12'(n), 32'h7A5A0000 + 32'(n));
        end
        for (int n = 0; n < 8; n++) begin
            rd_chk("foo_ram", 12'h040 + 12'(n), RAM_EN ? 32'hA0 + 32'(n) : 32'h0);
            rd_chk("bar0_ram", 12'h300 + 12'(n), RAM_EN ? 32'h7A5A0000 + 32'(n) : 32'h0);
        end
        wr(12'h048, 32'h55555555);
        rd_chk("foo_ram_beyond", 12'h048, 32'h0);
        rd_chk("bar1_ram_isolated", 12'h500, 32'h0);
        rd_chk("baz0_ram_isolated", 12'h700, 32'h0);

        // Counter: two samples five cycles apart
        @(negedge clk);
        gb_addr = 12'h001;
        @(negedge clk);
        c0 = gb_din;
        repeat (5) @(negedge clk);
        c1 = gb_din;
        chk("cnt_delta", (c1 - c0) & 32'h00FF_FFFF, 32'd5);
        chk("cnt_width", c1 & 32'hFF00_0000, 32'h0);

        // Read-during-write: old value first, new value next cycle
        @(negedge clk);
        gb_addr = 12'h201;
        gb_dout = 32'h11111111;
        gb_we   = 1'b1;
        @(negedge clk);
        gb_we = 1'b0;
        chk("rdw_old", gb_din, 32'hDADB00B5);
        @(negedge clk);
        chk("rdw_new", gb_din, 32'h11111111);

        // Reset mid-write: gb_din clears immediately, RAM retained, write lost
        gb_addr = 12'h300;
        gb_dout = 32'h99999999;
        gb_we   = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_gb_din", gb_din, 32'h0);
        @(negedge clk);
        gb_we = 1'b0;
        rst_n = 1'b1;
        rd_chk("rst2_foo_ha",   12'h000, 32'h0);
        rd_chk("rst2_bar0_two", 12'h201, 32'h0);
        rd_chk("rst2_bar1_two", 12'h401, 32'h0);
        rd_chk("rst2_baz0_ha",  12'h600, 32'h0);
        rd_chk("rst2_ram_write_dropped", 12'h300, RAM_EN ? 32'h7A5A0000 : 32'h0);
        rd_chk("rst2_foo_ram_kept", 12'h047, RAM_EN ? 32'hA7 : 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
